mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS core. Steps one instruction through FETCH/DECODE/EXEC/MEM/WB

---
 rtl/mips_pkg.sv | 35 +++
 rtl/mips_multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that drive the shared memory port and wait on memReady.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FSM, memory-wait watchdog, retire counter, trap flags.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             iorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             regDest,
  output logic             memToReg,
  output logic             regWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [1:0]       pcSource,
  output logic             retire,
  output logic [CNT_W-1:0] instrCount,
  output logic             illegal,
  output logic             busErr
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic               brNe_q;
  logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0]   count_q;
  logic               illegal_q, busErr_q;

  logic c_pcWrite, c_iorD, c_memRead, c_memWrite, c_irWrite;
  logic c_regDest, c_memToReg, c_regWrite, c_aluSrcA, c_retire;
  logic [1:0] c_aluSrcB, c_aluOp, c_pcSource;
  logic set_illegal, set_busErr, timeout;

  assign timeout = (waitCnt_q == WAIT_W'(MEM_TIMEOUT - 1)) && !memReady;

  // Next-state and control decode; memReady in the timeout cycle takes priority.
  always_comb begin
    state_d     = state_q;
    c_pcWrite   = 1'b0; c_iorD     = 1'b0; c_memRead  = 1'b0; c_memWrite = 1'b0;
    c_irWrite   = 1'b0; c_regDest  = 1'b0; c_memToReg = 1'b0; c_regWrite = 1'b0;
    c_aluSrcA   = 1'b0; c_retire   = 1'b0;
    c_aluSrcB   = SRCB_REGB; c_aluOp = ALUOP_ADD; c_pcSource = PCSRC_ALU;
    set_illegal = 1'b0;
    set_busErr  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        c_memRead = 1'b1;
        c_aluSrcB = SRCB_FOUR;
        if (memReady) begin
          c_irWrite = 1'b1;
          c_pcWrite = 1'b1;
          state_d   = S_DECODE;
        end else if (timeout) begin
          set_busErr = 1'b1;
          state_d    = S_TRAP;
        end
      end
      S_DECODE: begin
        c_aluSrcB = SRCB_IMMSH;
        case (opcode)
          OP_R:           state_d = S_EXEC;
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default: begin
            set_illegal = 1'b1;
            state_d     = S_TRAP;
          end
        endcase
      end
      S_EXEC: begin
        c_aluSrcA = 1'b1;
        c_aluOp   = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        c_regDest  = 1'b1;
        c_regWrite = 1'b1;
        c_retire   = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMADR: begin
        c_aluSrcA = 1'b1;
        c_aluSrcB = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        c_memRead = 1'b1;
        c_iorD    = 1'b1;
        if (memReady) state_d = S_MEMWB;
        else if (timeout) begin
          set_busErr = 1'b1;
          state_d    = S_TRAP;
        end
      end
      S_MEMWB: begin
        c_memToReg = 1'b1;
        c_regWrite = 1'b1;
        c_retire   = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        c_memWrite = 1'b1;
        c_iorD     = 1'b1;
        if (memReady) begin
          c_retire = 1'b1;
          state_d  = S_FETCH;
        end else if (timeout) begin
          set_busErr = 1'b1;
          state_d    = S_TRAP;
        end
      end
      S_ADDIEX: begin
        c_aluSrcA = 1'b1;
        c_aluSrcB = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        c_regWrite = 1'b1;
        c_retire   = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        c_aluSrcA  = 1'b1;
        c_aluOp    = ALUOP_SUB;
        c_pcSource = PCSRC_ALUOUT;
        c_pcWrite  = brNe_q ? ~zero : zero;
        c_retire   = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        c_pcSource = PCSRC_JUMP;
        c_pcWrite  = 1'b1;
        c_retire   = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Wait counter runs only while a memory state is held; any transition clears it.
  always_comb begin
    waitCnt_d = '0;
    if (is_mem_state(state_q) && (state_d == state_q) && !memReady)
      waitCnt_d = waitCnt_q + WAIT_W'(1);
  end

  // State, latched branch type, wait counter, retire counter and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      brNe_q    <= 1'b0;
      waitCnt_q <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      busErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      if (state_q == S_DECODE) brNe_q <= (opcode == OP_BNE);
      if (c_retire) count_q <= count_q + CNT_W'(1);
      illegal_q <= illegal_q | set_illegal;
      busErr_q  <= busErr_q | set_busErr;
    end
  end

  // Controls are forced low while reset is held, since the reset state itself decodes as FETCH.
  always_comb begin
    pcWrite  = c_pcWrite  & ~reset;
    iorD     = c_iorD     & ~reset;
    memRead  = c_memRead  & ~reset;
    memWrite = c_memWrite & ~reset;
    irWrite  = c_irWrite  & ~reset;
    regDest  = c_regDest  & ~reset;
    memToReg = c_memToReg & ~reset;
    regWrite = c_regWrite & ~reset;
    aluSrcA  = c_aluSrcA  & ~reset;
    aluSrcB  = reset ? '0 : c_aluSrcB;
    aluOp    = reset ? '0 : c_aluOp;
    pcSource = reset ? '0 : c_pcSource;
    retire   = c_retire   & ~reset;
  end

  assign instrCount = count_q;
  assign illegal    = illegal_q;
  assign busErr     = busErr_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: vector table plus multi-cycle corner sequences.
module tb_mips_multicycle_ctrl;

  // Packed control word: {pcWrite,iorD,memRead,memWrite,irWrite,regDest,memToReg,regWrite,
  //                       aluSrcA,aluSrcB[1:0],aluOp[1:0],pcSource[1:0],retire}
  localparam logic [15:0] C_FETCHW  = 16'h2020;
  localparam logic [15:0] C_FETCHR  = 16'hA820;
  localparam logic [15:0] C_DECODE  = 16'h0060;
  localparam logic [15:0] C_EXEC    = 16'h0090;
  localparam logic [15:0] C_ALUWB   = 16'h0501;
  localparam logic [15:0] C_MEMADR  = 16'h00C0;
  localparam logic [15:0] C_MEMRD   = 16'h6000;
  localparam logic [15:0] C_MEMWB   = 16'h0301;
  localparam logic [15:0] C_MEMWRW  = 16'h5000;
  localparam logic [15:0] C_MEMWRR  = 16'h5001;
  localparam logic [15:0] C_ADDIEX  = 16'h00C0;
  localparam logic [15:0] C_ADDIWB  = 16'h0101;
  localparam logic [15:0] C_BRNT    = 16'h008B;
  localparam logic [15:0] C_BRT     = 16'h808B;
  localparam logic [15:0] C_JUMP    = 16'h8005;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [15:0] ctrl;
    logic        ill;
    logic        be;
    logic [3:0]  cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = '0;
  logic zero = 1'b0;
  logic memReady = 1'b0;
  logic pcWrite, iorD, memRead, memWrite, irWrite, regDest, memToReg, regWrite, aluSrcA, retire;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] instrCount;
  logic illegal, busErr;
  logic [15:0] act;

  int total = 0;
  int passed = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
    .pcWrite(pcWrite), .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .regDest(regDest), .memToReg(memToReg), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
    .retire(retire), .instrCount(instrCount), .illegal(illegal), .busErr(busErr)
  );

  assign act = {pcWrite, iorD, memRead, memWrite, irWrite, regDest, memToReg, regWrite,
                aluSrcA, aluSrcB, aluOp, pcSource, retire};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic add(input logic [5:0] op, input logic z, input logic rdy, input logic [15:0] c,
                     input logic ill, input logic be, input logic [3:0] cnt);
    vec_t v;
    v.op = op; v.z = z; v.rdy = rdy; v.ctrl = c; v.ill = ill; v.be = be; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset ctrl", 32'(act), 32'h0);
    check("reset cnt", 32'(instrCount), 32'h0);
    check("reset flags", {30'h0, illegal, busErr}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drive(input logic [5:0] op, input logic z, input logic rdy);
    opcode = op; zero = z; memReady = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // R-type
    add(6'h00, 0, 1, C_FETCHR, 0, 0, 0); add(6'h00, 0, 1, C_DECODE, 0, 0, 0);
    add(6'h00, 0, 1, C_EXEC,   0, 0, 0); add(6'h00, 0, 1, C_ALUWB,  0, 0, 0);
    // LW with three wait cycles in MEMRD
    add(6'h23, 0, 1, C_FETCHR, 0, 0, 1); add(6'h23, 0, 1, C_DECODE, 0, 0, 1);
    add(6'h23, 0, 1, C_MEMADR, 0, 0, 1); add(6'h23, 0, 0, C_MEMRD,  0, 0, 1);
    add(6'h23, 0, 0, C_MEMRD,  0, 0, 1); add(6'h23, 0, 0, C_MEMRD,  0, 0, 1);
    add(6'h23, 0, 1, C_MEMRD,  0, 0, 1); add(6'h23, 0, 1, C_MEMWB,  0, 0, 1);
    // SW with one wait cycle
    add(6'h2B, 0, 1, C_FETCHR, 0, 0, 2); add(6'h2B, 0, 1, C_DECODE, 0, 0, 2);
    add(6'h2B, 0, 1, C_MEMADR, 0, 0, 2); add(6'h2B, 0, 0, C_MEMWRW, 0, 0, 2);
    add(6'h2B, 0, 1, C_MEMWRR, 0, 0, 2);
    // ADDI
    add(6'h08, 0, 1, C_FETCHR, 0, 0, 3); add(6'h08, 0, 1, C_DECODE, 0, 0, 3);
    add(6'h08, 0, 1, C_ADDIEX, 0, 0, 3); add(6'h08, 0, 1, C_ADDIWB, 0, 0, 3);
    // Branches: BEQ z=1 taken, BNE z=1 not, BEQ z=0 not, BNE z=0 taken
    add(6'h04, 1, 1, C_FETCHR, 0, 0, 4); add(6'h04, 1, 1, C_DECODE, 0, 0, 4);
    add(6'h04, 1, 1, C_BRT,    0, 0, 4);
    add(6'h05, 1, 1, C_FETCHR, 0, 0, 5); add(6'h05, 1, 1, C_DECODE, 0, 0, 5);
    add(6'h05, 1, 1, C_BRNT,   0, 0, 5);
    add(6'h04, 0, 1, C_FETCHR, 0, 0, 6); add(6'h04, 0, 1, C_DECODE, 0, 0, 6);
    add(6'h04, 0, 1, C_BRNT,   0, 0, 6);
    add(6'h05, 0, 1, C_FETCHR, 0, 0, 7); add(6'h05, 0, 1, C_DECODE, 0, 0, 7);
    add(6'h05, 0, 1, C_BRT,    0, 0, 7);
    // Jump
    add(6'h02, 0, 1, C_FETCHR, 0, 0, 8); add(6'h02, 0, 1, C_DECODE, 0, 0, 8);
    add(6'h02, 0, 1, C_JUMP,   0, 0, 8);
    add(6'h02, 0, 0, C_FETCHW, 0, 0, 9);

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].z, vecs[i].rdy);
      @(negedge clk);
      check($sformatf("row%0d ctrl", i), 32'(act), 32'(vecs[i].ctrl));
      check($sformatf("row%0d cnt", i), 32'(instrCount), 32'(vecs[i].cnt));
      check($sformatf("row%0d flags", i), {30'h0, illegal, busErr}, {30'h0, vecs[i].ill, vecs[i].be});
      tick();
    end

    // Illegal opcode: TRAP after DECODE, outputs 0 and illegal held for 20 cycles
    drive(6'h3F, 0, 1); tick();
    @(negedge clk);
    check("ill decode ctrl", 32'(act), 32'(C_DECODE));
    check("ill decode flag", 32'(illegal), 32'h0);
    tick();
    for (int unsigned k = 0; k < 20; k++) begin
      drive(6'h3F, k[0], k[1]);
      @(negedge clk);
      check($sformatf("trap%0d ctrl", k), 32'(act), 32'h0);
      check($sformatf("trap%0d ill", k), 32'(illegal), 32'h1);
      tick();
    end
    do_reset();
    drive(6'h00, 0, 0);
    @(negedge clk);
    check("post-trap fetch", 32'(act), 32'(C_FETCHW));
    check("post-trap ill", 32'(illegal), 32'h0);

    // Fetch timeout: memReady never arrives, busErr on the 16th edge
    do_reset();
    drive(6'h00, 0, 0);
    for (int unsigned k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("to cyc%0d ctrl", k), 32'(act), 32'(C_FETCHW));
      check($sformatf("to cyc%0d be", k), 32'(busErr), 32'h0);
      tick();
    end
    check("timeout busErr", 32'(busErr), 32'h1);
    check("timeout ctrl", 32'(act), 32'h0);

    // memReady in the 16th cycle wins over the timeout
    do_reset();
    drive(6'h00, 0, 0);
    for (int unsigned k = 1; k <= 15; k++) tick();
    drive(6'h00, 0, 1);
    @(negedge clk);
    check("late rdy ctrl", 32'(act), 32'(C_FETCHR));
    tick();
    check("late rdy decode", 32'(act), 32'(C_DECODE));
    check("late rdy be", 32'(busErr), 32'h0);

    // Reset mid-MEMWR: aborts with no retire, outputs and counter clear immediately
    do_reset();
    drive(6'h02, 0, 1); tick(); tick(); tick();
    check("pre-abort cnt", 32'(instrCount), 32'h1);
    drive(6'h2B, 0, 1); tick(); tick(); tick();
    drive(6'h2B, 0, 0);
    @(negedge clk);
    check("memwr wait ctrl", 32'(act), 32'(C_MEMWRW));
    reset = 1'b1;
    #1;
    check("abort ctrl", 32'(act), 32'h0);
    check("abort cnt", 32'(instrCount), 32'h0);
    tick();
    reset = 1'b0;

    // Counter wrap with CNT_W=4: 16 jumps
    drive(6'h02, 0, 1);
    for (int unsigned n = 1; n <= 16; n++) begin
      tick(); tick(); tick();
      if (n == 15) check("cnt at 15", 32'(instrCount), 32'hF);
    end
    check("cnt wrap", 32'(instrCount), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
